// File: rtl/nanci_phase_ctrl.sv
// rtl/nanci_phase_ctrl.sv - LOAD/SORT/COMPUTE phase sequencer for a NANCI PE array
module nanci_phase_ctrl #(
  parameter int ADDR_WIDTH     = 3,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_phase,
  output logic [1:0]            o_dir,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic                  o_pe_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_COMPUTE,
    S_DONE
  } state_t;

  localparam logic [7:0]            SORT_LAST    = 8'(SORT_CYCLES - 1);
  localparam logic [7:0]            COMPUTE_LAST = 8'(COMPUTE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = '1;

  state_t     state;
  logic [7:0] phase_cnt;
  logic [1:0] step_cnt;

  always_ff @(posedge clk) begin
    // o_busy is high exactly in LOAD/SORT/COMPUTE, so it doubles as the abort qualifier
    if (rst || (i_abort && o_busy)) begin
      state      <= S_IDLE;
      phase_cnt  <= 8'd0;
      step_cnt   <= 2'd0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_phase    <= 2'b00;
      o_dir      <= 2'b00;
      o_mem_addr <= '0;
      o_mem_we   <= 1'b0;
      o_pe_en    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state      <= S_LOAD;
            o_busy     <= 1'b1;
            o_phase    <= 2'b01;
            o_mem_we   <= 1'b1;
            o_mem_addr <= '0;
          end
        end
        S_LOAD: begin
          if (o_mem_addr == ADDR_LAST) begin
            state      <= S_SORT;
            o_phase    <= 2'b10;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_pe_en    <= 1'b1;
            o_dir      <= 2'b00;
            step_cnt   <= 2'd0;
            phase_cnt  <= 8'd0;
          end else begin
            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
          end
        end
        S_SORT: begin
          if (phase_cnt == SORT_LAST) begin
            state     <= S_COMPUTE;
            o_phase   <= 2'b11;
            o_dir     <= 2'b00;
            step_cnt  <= 2'd0;
            phase_cnt <= 8'd0;
          end else begin
            // route select cycles l,r,u,d; the 2-bit step counter wraps freely
            phase_cnt <= phase_cnt + 8'd1;
            step_cnt  <= step_cnt + 2'd1;
            o_dir     <= step_cnt + 2'd1;
          end
        end
        S_COMPUTE: begin
          if (phase_cnt == COMPUTE_LAST) begin
            state     <= S_DONE;
            phase_cnt <= 8'd0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_phase   <= 2'b00;
            o_pe_en   <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// tb/tb_nanci_phase_ctrl.sv - directed self-checking bench for nanci_phase_ctrl
module tb_nanci_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_start, i_abort;

  logic       m_busy, m_done, m_we, m_pe;
  logic [1:0] m_phase, m_dir;
  logic [2:0] m_addr;
  logic       n_busy, n_done, n_we, n_pe;
  logic [1:0] n_phase, n_dir;
  logic [0:0] n_addr;
  logic       w_busy, w_done, w_we, w_pe;
  logic [1:0] w_phase, w_dir;
  logic [2:0] w_addr;

  nanci_phase_ctrl #(.ADDR_WIDTH(3), .SORT_CYCLES(4), .COMPUTE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_busy(m_busy), .o_done(m_done), .o_phase(m_phase), .o_dir(m_dir),
    .o_mem_addr(m_addr), .o_mem_we(m_we), .o_pe_en(m_pe)
  );

  nanci_phase_ctrl #(.ADDR_WIDTH(1), .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_busy(n_busy), .o_done(n_done), .o_phase(n_phase), .o_dir(n_dir),
    .o_mem_addr(n_addr), .o_mem_we(n_we), .o_pe_en(n_pe)
  );

  nanci_phase_ctrl #(.ADDR_WIDTH(3), .SORT_CYCLES(6), .COMPUTE_CYCLES(2)) dut_wrap (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .o_busy(w_busy), .o_done(w_done), .o_phase(w_phase), .o_dir(w_dir),
    .o_mem_addr(w_addr), .o_mem_we(w_we), .o_pe_en(w_pe)
  );

  // {busy, done, phase, dir, addr[7:0], we, pe_en}
  logic [15:0] v_main, v_min, v_wrap;
  assign v_main = {m_busy, m_done, m_phase, m_dir, {5'b0, m_addr}, m_we, m_pe};
  assign v_min  = {n_busy, n_done, n_phase, n_dir, {7'b0, n_addr}, n_we, n_pe};
  assign v_wrap = {w_busy, w_done, w_phase, w_dir, {5'b0, w_addr}, w_we, w_pe};

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected output vector c cycles after the start edge (c=0 is idle before the run)
  function automatic logic [15:0] exp_vec(input int c, input int aw, input int sc, input int cc);
    int l;
    logic [15:0] v;
    l = 1 << aw;
    v = 16'h0000;
    if (c >= 1 && c <= l)
      v = {1'b1, 1'b0, 2'b01, 2'b00, 8'(c - 1), 1'b1, 1'b0};
    else if (c > l && c <= l + sc)
      v = {1'b1, 1'b0, 2'b10, 2'((c - l - 1) % 4), 8'd0, 1'b0, 1'b1};
    else if (c > l + sc && c <= l + sc + cc)
      v = {1'b1, 1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b1};
    else if (c == l + sc + cc + 1)
      v = {1'b0, 1'b1, 14'd0};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_abort = 1'b0;
    step(); step();
    n_cmp++; if (v_main !== 16'h0) begin n_fail++; $display("FAIL reset_main got %h exp %h", v_main, 16'h0); end
    n_cmp++; if (v_min  !== 16'h0) begin n_fail++; $display("FAIL reset_min got %h exp %h", v_min, 16'h0); end
    n_cmp++; if (v_wrap !== 16'h0) begin n_fail++; $display("FAIL reset_wrap got %h exp %h", v_wrap, 16'h0); end
    rst = 1'b0; i_start = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    launch();
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (v_main !== exp_vec(c, 3, 4, 2)) begin
        n_fail++; $display("FAIL nominal c=%0d got %h exp %h", c, v_main, exp_vec(c, 3, 4, 2));
      end
      step();
    end
  endtask

  task automatic test_abort_with_start();
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    n_cmp++; if (v_main !== 16'h0) begin n_fail++; $display("FAIL abort_start_idle got %h exp %h", v_main, 16'h0); end
    step();
    n_cmp++; if (v_main !== 16'h0) begin n_fail++; $display("FAIL abort_start_idle2 got %h exp %h", v_main, 16'h0); end
  endtask

  task automatic test_abort();
    launch();
    for (int c = 1; c < 10; c++) step();
    n_cmp++;
    if (v_main !== exp_vec(10, 3, 4, 2)) begin
      n_fail++; $display("FAIL abort_pre got %h exp %h", v_main, exp_vec(10, 3, 4, 2));
    end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    for (int c = 11; c <= 30; c++) begin
      n_cmp++;
      if (v_main !== 16'h0) begin n_fail++; $display("FAIL abort_idle c=%0d got %h exp %h", c, v_main, 16'h0); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    launch();
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (v_main !== exp_vec(c, 3, 4, 2)) begin
        n_fail++; $display("FAIL busy_start c=%0d got %h exp %h", c, v_main, exp_vec(c, 3, 4, 2));
      end
      if (m_done === 1'b1) dones++;
      i_start = (c == 5 || c == 15 || c == 16);
      step();
    end
    i_start = 1'b0;
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d exp %0d", dones, 1); end
    n_cmp++;
    if (v_main !== exp_vec(1, 3, 4, 2)) begin
      n_fail++; $display("FAIL restart_c17 got %h exp %h", v_main, exp_vec(1, 3, 4, 2));
    end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    launch();
    for (int c = 1; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (v_main !== 16'h0) begin n_fail++; $display("FAIL reset_mid got %h exp %h", v_main, 16'h0); end
    launch();
    for (int c = 1; c <= 16; c++) begin
      n_cmp++;
      if (v_main !== exp_vec(c, 3, 4, 2)) begin
        n_fail++; $display("FAIL after_reset c=%0d got %h exp %h", c, v_main, exp_vec(c, 3, 4, 2));
      end
      step();
    end
  endtask

  task automatic test_min_params();
    rst = 1'b1; step(); rst = 1'b0;
    launch();
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if (v_min !== exp_vec(c, 1, 1, 1)) begin
        n_fail++; $display("FAIL min_params c=%0d got %h exp %h", c, v_min, exp_vec(c, 1, 1, 1));
      end
      step();
    end
  endtask

  task automatic test_dir_wrap();
    rst = 1'b1; step(); rst = 1'b0;
    launch();
    for (int c = 1; c <= 18; c++) begin
      n_cmp++;
      if (v_wrap !== exp_vec(c, 3, 6, 2)) begin
        n_fail++; $display("FAIL dir_wrap c=%0d got %h exp %h", c, v_wrap, exp_vec(c, 3, 6, 2));
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    test_reset();
    test_nominal();
    test_abort_with_start();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_min_params();
    test_dir_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
